// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared RV32I definitions for the decode slice: default widths, the base
// opcode encodings and the bit offsets of the register fields inside an
// instruction word. Also holds two small helpers that tell which source
// registers a given opcode reads, used by the load-use hazard check.
// ---------------------------------------------------------------------------
package rv_pkg;

    // Default widths for a plain RV32I core.
    localparam int XLEN_DEF = 32;
    localparam int PC_W_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int RA_W_DEF = 5;

    // Bit positions of the register address fields in an instruction.
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    // Base RV32I major opcodes (inst[6:0]).
    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    // rs1 is a real operand for R, I (load/op-imm/jalr), S and B formats.
    function automatic logic usesRs1(input logic [6:0] op);
        logic used;
        used = 1'b0;
        case (op)
            OP_REG, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH: used = 1'b1;
            default: used = 1'b0;
        endcase
        return used;
    endfunction

    // rs2 is a real operand only for R, S and B formats; in I-type the same
    // bits hold immediate, so they must not raise a false hazard.
    function automatic logic usesRs2(input logic [6:0] op);
        logic used;
        used = 1'b0;
        case (op)
            OP_REG, OP_STORE, OP_BRANCH: used = 1'b1;
            default: used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/id_regfile_bypass.sv
// ---------------------------------------------------------------------------
// id_regfile_bypass
// NREG x XLEN architectural register file with two combinational read ports
// and one synchronous write port. x0 always reads zero and ignores writes.
// A write happening in the same cycle as a read of the same register is
// forwarded straight to the read port, so decode sees the newest value.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous, active-low reset; clears every entry
//   i_we         write enable
//   i_wr_addr    write destination register
//   i_wr_data    write data
//   i_rs1_addr   read port 1 address
//   i_rs2_addr   read port 2 address
//   o_rs1_data   read port 1 data (bypassed)
//   o_rs2_data   read port 2 data (bypassed)
//
// NREG must equal 2**RA_W so every address maps to an entry.
// ---------------------------------------------------------------------------
module id_regfile_bypass
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_we,
    input  logic [RA_W-1:0] i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [RA_W-1:0] i_rs1_addr,
    input  logic [RA_W-1:0] i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wr_live;

    // A write only counts when it targets a real register; x0 writes are
    // dropped here so neither storage nor bypass ever sees them.
    assign w_wr_live = i_we && (i_wr_addr != '0);

    // Storage update: reset has priority so a write-back arriving in the
    // reset cycle is discarded along with everything else.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port 1: x0 is forced to zero, otherwise a matching write-back
    // wins over the stored value.
    always_comb begin
        o_rs1_data = r_regs[i_rs1_addr];
        if (i_rs1_addr == '0) begin
            o_rs1_data = '0;
        end else if (w_wr_live && (i_wr_addr == i_rs1_addr)) begin
            o_rs1_data = i_wr_data;
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        o_rs2_data = r_regs[i_rs2_addr];
        if (i_rs2_addr == '0) begin
            o_rs2_data = '0;
        end else if (w_wr_live && (i_wr_addr == i_rs2_addr)) begin
            o_rs2_data = i_wr_data;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// RV32I instruction-decode stage with a registered ID/EX boundary. Accepts a
// PC/instruction beat from IF over valid/ready, reads operands from the
// register file (with write-back bypass), builds the sign-extended immediate
// and registers the whole bundle for EX. Supports EX backpressure, flush of
// the entry being loaded, and a one-cycle bubble for load-use hazards.
//
// Ports:
//   i_clk, i_rst         clock (rising edge), synchronous active-low reset
//   i_if_valid/pc/inst   fetched beat from IF
//   o_if_ready           ID accepts the IF beat this cycle
//   i_flush              kill the instruction entering ID/EX
//   i_ex_ready           EX consumes the current ID/EX entry
//   i_wb_we/rd/data      write-back port into the register file
//   o_ex_*               registered ID/EX bundle (valid, pc, operands, imm,
//                        register addresses, opcode, funct3, inst[30])
//   o_hazard             load-use bubble is being inserted this cycle
// ---------------------------------------------------------------------------
module id_stage_pipe
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int PC_W = PC_W_DEF,
    parameter int NREG = NREG_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_valid,
    input  logic [PC_W-1:0] i_if_pc,
    input  logic [31:0]     i_if_inst,
    output logic            o_if_ready,
    input  logic            i_flush,
    input  logic            i_ex_ready,
    input  logic            i_wb_we,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_ex_valid,
    output logic [PC_W-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_rs1_data,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [RA_W-1:0] o_ex_rs1,
    output logic [RA_W-1:0] o_ex_rs2,
    output logic [RA_W-1:0] o_ex_rd,
    output logic [6:0]      o_ex_opcode,
    output logic [2:0]      o_ex_funct3,
    output logic            o_ex_funct7b5,
    output logic            o_hazard
);

    // Immediate generation for every base format. The 32-bit immediate is
    // assembled first and then sign-extended to XLEN via a signed cast.
    function automatic logic [XLEN-1:0] genImm(input logic [31:0] inst);
        logic [31:0] imm32;
        imm32 = '0;
        case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm32 = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                         inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {inst[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                         inst[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        return XLEN'($signed(imm32));
    endfunction

    // Registered ID/EX bundle.
    logic            r_ex_valid;
    logic [PC_W-1:0] r_ex_pc;
    logic [XLEN-1:0] r_ex_rs1_data;
    logic [XLEN-1:0] r_ex_rs2_data;
    logic [XLEN-1:0] r_ex_imm;
    logic [RA_W-1:0] r_ex_rs1;
    logic [RA_W-1:0] r_ex_rs2;
    logic [RA_W-1:0] r_ex_rd;
    logic [6:0]      r_ex_opcode;
    logic [2:0]      r_ex_funct3;
    logic            r_ex_funct7b5;

    // Decoded fields of the incoming IF beat.
    logic [RA_W-1:0] w_rs1;
    logic [RA_W-1:0] w_rs2;
    logic [RA_W-1:0] w_rd;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_funct7b5;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_adv;
    logic            w_load_in_ex;
    logic            w_hazard;

    assign w_rs1      = i_if_inst[RS1_LSB +: RA_W];
    assign w_rs2      = i_if_inst[RS2_LSB +: RA_W];
    assign w_rd       = i_if_inst[RD_LSB  +: RA_W];
    assign w_opcode   = i_if_inst[6:0];
    assign w_funct3   = i_if_inst[14:12];
    assign w_funct7b5 = i_if_inst[30];
    assign w_imm      = genImm(i_if_inst);

    id_regfile_bypass #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RA_W (RA_W)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (i_wb_we),
        .i_wr_addr  (i_wb_rd),
        .i_wr_data  (i_wb_data),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data)
    );

    // The ID/EX register can take a new entry when it is empty or EX is
    // draining it this cycle.
    assign w_adv = !r_ex_valid || i_ex_ready;

    // Load-use: a load sitting in ID/EX whose result the incoming
    // instruction actually reads. Loads to x0 never stall anything.
    assign w_load_in_ex = r_ex_valid && (r_ex_opcode == OP_LOAD) &&
                          (r_ex_rd != '0);
    assign w_hazard = w_load_in_ex && i_if_valid &&
                      ((usesRs1(w_opcode) && (r_ex_rd == w_rs1)) ||
                       (usesRs2(w_opcode) && (r_ex_rd == w_rs2)));

    assign o_hazard   = w_hazard;
    assign o_if_ready = w_adv && !w_hazard;

    // ID/EX register update. Reset first, then flush (beats stall and
    // hazard), then the load-use bubble, then a normal capture; with none of
    // those the entry holds because EX is stalled. Flush and bubble only
    // clear the valid bit; the payload is left as is since EX ignores it.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_opcode   <= '0;
            r_ex_funct3   <= '0;
            r_ex_funct7b5 <= 1'b0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_adv && w_hazard) begin
            r_ex_valid <= 1'b0;
        end else if (w_adv) begin
            r_ex_valid    <= i_if_valid;
            r_ex_pc       <= i_if_pc;
            r_ex_rs1_data <= w_rs1_data;
            r_ex_rs2_data <= w_rs2_data;
            r_ex_imm      <= w_imm;
            r_ex_rs1      <= w_rs1;
            r_ex_rs2      <= w_rs2;
            r_ex_rd       <= w_rd;
            r_ex_opcode   <= w_opcode;
            r_ex_funct3   <= w_funct3;
            r_ex_funct7b5 <= w_funct7b5;
        end
    end

    assign o_ex_valid    = r_ex_valid;
    assign o_ex_pc       = r_ex_pc;
    assign o_ex_rs1_data = r_ex_rs1_data;
    assign o_ex_rs2_data = r_ex_rs2_data;
    assign o_ex_imm      = r_ex_imm;
    assign o_ex_rs1      = r_ex_rs1;
    assign o_ex_rs2      = r_ex_rs2;
    assign o_ex_rd       = r_ex_rd;
    assign o_ex_opcode   = r_ex_opcode;
    assign o_ex_funct3   = r_ex_funct3;
    assign o_ex_funct7b5 = r_ex_funct7b5;

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
// Directed bench for id_stage_pipe: reset, decode/immediates, register-file
// bypass and x0, load-use bubbles, EX backpressure and flush priority.
// Expected values are hand-decoded from the instruction encodings below.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

    localparam int XLEN = 32;
    localparam int PC_W = 32;
    localparam int NREG = 32;
    localparam int RA_W = 5;

    // Hand-encoded instructions.
    localparam logic [31:0] ADDI_X5_X1_M1 = 32'hFFF08293; // addi x5,x1,-1
    localparam logic [31:0] BEQ_M4        = 32'hFE000EE3; // beq x0,x0,-4
    localparam logic [31:0] ADDI_X8_X3    = 32'h00018413; // addi x8,x3,0
    localparam logic [31:0] ADDI_X9_X0    = 32'h00000493; // addi x9,x0,0
    localparam logic [31:0] LW_X6_X2      = 32'h00012303; // lw x6,0(x2)
    localparam logic [31:0] ADD_X7_X6_X1  = 32'h001303B3; // add x7,x6,x1
    localparam logic [31:0] LUI_X6        = 32'h12345337; // lui x6,0x12345
    localparam logic [31:0] LW_X0_X2      = 32'h00012003; // lw x0,0(x2)
    localparam logic [31:0] ADD_X7_X0_X0  = 32'h000003B3; // add x7,x0,x0

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_if_valid;
    logic [PC_W-1:0] i_if_pc;
    logic [31:0]     i_if_inst;
    logic            o_if_ready;
    logic            i_flush;
    logic            i_ex_ready;
    logic            i_wb_we;
    logic [RA_W-1:0] i_wb_rd;
    logic [XLEN-1:0] i_wb_data;
    logic            o_ex_valid;
    logic [PC_W-1:0] o_ex_pc;
    logic [XLEN-1:0] o_ex_rs1_data;
    logic [XLEN-1:0] o_ex_rs2_data;
    logic [XLEN-1:0] o_ex_imm;
    logic [RA_W-1:0] o_ex_rs1;
    logic [RA_W-1:0] o_ex_rs2;
    logic [RA_W-1:0] o_ex_rd;
    logic [6:0]      o_ex_opcode;
    logic [2:0]      o_ex_funct3;
    logic            o_ex_funct7b5;
    logic            o_hazard;

    int checks   = 0;
    int failures = 0;

    id_stage_pipe #(
        .XLEN (XLEN),
        .PC_W (PC_W),
        .NREG (NREG),
        .RA_W (RA_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_if_valid    (i_if_valid),
        .i_if_pc       (i_if_pc),
        .i_if_inst     (i_if_inst),
        .o_if_ready    (o_if_ready),
        .i_flush       (i_flush),
        .i_ex_ready    (i_ex_ready),
        .i_wb_we       (i_wb_we),
        .i_wb_rd       (i_wb_rd),
        .i_wb_data     (i_wb_data),
        .o_ex_valid    (o_ex_valid),
        .o_ex_pc       (o_ex_pc),
        .o_ex_rs1_data (o_ex_rs1_data),
        .o_ex_rs2_data (o_ex_rs2_data),
        .o_ex_imm      (o_ex_imm),
        .o_ex_rs1      (o_ex_rs1),
        .o_ex_rs2      (o_ex_rs2),
        .o_ex_rd       (o_ex_rd),
        .o_ex_opcode   (o_ex_opcode),
        .o_ex_funct3   (o_ex_funct3),
        .o_ex_funct7b5 (o_ex_funct7b5),
        .o_hazard      (o_hazard)
    );

    // 10 ns clock.
    always #5 i_clk = ~i_clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one IF beat.
    task automatic applyStimulus(input logic valid, input logic [PC_W-1:0] pc,
                                 input logic [31:0] inst);
        i_if_valid = valid;
        i_if_pc    = pc;
        i_if_inst  = inst;
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive a write-back (or clear it with we=0).
    task automatic driveWb(input logic we, input logic [RA_W-1:0] rd,
                           input logic [XLEN-1:0] data);
        i_wb_we   = we;
        i_wb_rd   = rd;
        i_wb_data = data;
    endtask

    initial begin
        i_rst      = 1'b0;
        i_flush    = 1'b0;
        i_ex_ready = 1'b1;
        driveWb(1'b0, '0, '0);
        applyStimulus(1'b1, 32'h40, ADDI_X5_X1_M1);

        // Reset held for two edges with a valid IF beat present.
        tick();
        tick();
        checkOutput("rst_valid",  o_ex_valid,    0);
        checkOutput("rst_pc",     o_ex_pc,       0);
        checkOutput("rst_imm",    o_ex_imm,      0);
        checkOutput("rst_rd",     o_ex_rd,       0);
        checkOutput("rst_opcode", o_ex_opcode,   0);
        checkOutput("rst_rs1d",   o_ex_rs1_data, 0);
        checkOutput("rst_hazard", o_hazard,      0);

        // Load x1 = 7 through write-back.
        i_rst = 1'b1;
        applyStimulus(1'b0, '0, '0);
        driveWb(1'b1, 5'd1, 32'd7);
        tick();
        driveWb(1'b0, '0, '0);

        // addi x5,x1,-1 at PC 0x100.
        applyStimulus(1'b1, 32'h100, ADDI_X5_X1_M1);
        tick();
        checkOutput("addi_valid",  o_ex_valid,    1);
        checkOutput("addi_pc",     o_ex_pc,       32'h100);
        checkOutput("addi_imm",    o_ex_imm,      32'hFFFFFFFF);
        checkOutput("addi_rs1d",   o_ex_rs1_data, 32'd7);
        checkOutput("addi_rd",     o_ex_rd,       5);
        checkOutput("addi_rs1",    o_ex_rs1,      1);
        checkOutput("addi_opcode", o_ex_opcode,   7'h13);
        checkOutput("addi_funct3", o_ex_funct3,   0);

        // beq x0,x0,-4.
        applyStimulus(1'b1, 32'h104, BEQ_M4);
        tick();
        checkOutput("beq_imm",    o_ex_imm,      32'hFFFFFFFC);
        checkOutput("beq_opcode", o_ex_opcode,   7'h63);
        checkOutput("beq_f7b5",   o_ex_funct7b5, 1);

        // Same-cycle write-through of x3, then the stored value.
        applyStimulus(1'b1, 32'h108, ADDI_X8_X3);
        driveWb(1'b1, 5'd3, 32'hDEADBEEF);
        tick();
        driveWb(1'b0, '0, '0);
        checkOutput("bypass_rs1d", o_ex_rs1_data, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h10C, ADDI_X8_X3);
        tick();
        checkOutput("stored_rs1d", o_ex_rs1_data, 32'hDEADBEEF);

        // Write-back to x0 is neither bypassed nor stored.
        applyStimulus(1'b1, 32'h110, ADDI_X9_X0);
        driveWb(1'b1, 5'd0, 32'd5);
        tick();
        driveWb(1'b0, '0, '0);
        checkOutput("x0_bypass", o_ex_rs1_data, 0);
        tick();
        checkOutput("x0_stored", o_ex_rs1_data, 0);

        // Load-use: lw x6 then add x7,x6,x1 -> one bubble.
        applyStimulus(1'b1, 32'h120, LW_X6_X2);
        tick();
        checkOutput("lw_valid",  o_ex_valid,  1);
        checkOutput("lw_opcode", o_ex_opcode, 7'h03);
        checkOutput("lw_funct3", o_ex_funct3, 2);
        applyStimulus(1'b1, 32'h124, ADD_X7_X6_X1);
        #1;
        checkOutput("lu_hazard", o_hazard,   1);
        checkOutput("lu_ready",  o_if_ready, 0);
        tick();
        checkOutput("bubble_valid",  o_ex_valid, 0);
        checkOutput("bubble_hazard", o_hazard,   0);
        checkOutput("bubble_ready",  o_if_ready, 1);
        tick();
        checkOutput("add_valid", o_ex_valid,    1);
        checkOutput("add_pc",    o_ex_pc,       32'h124);
        checkOutput("add_rd",    o_ex_rd,       7);
        checkOutput("add_rs2d",  o_ex_rs2_data, 32'd7);

        // lw x6 followed by lui x6: lui reads nothing, no bubble.
        applyStimulus(1'b1, 32'h128, LW_X6_X2);
        tick();
        applyStimulus(1'b1, 32'h12C, LUI_X6);
        #1;
        checkOutput("lui_hazard", o_hazard,   0);
        checkOutput("lui_ready",  o_if_ready, 1);
        tick();
        checkOutput("lui_valid", o_ex_valid, 1);
        checkOutput("lui_pc",    o_ex_pc,    32'h12C);
        checkOutput("lui_imm",   o_ex_imm,   32'h12345000);

        // Load to x0 never raises a hazard.
        applyStimulus(1'b1, 32'h130, LW_X0_X2);
        tick();
        applyStimulus(1'b1, 32'h134, ADD_X7_X0_X0);
        #1;
        checkOutput("lwx0_hazard", o_hazard, 0);
        tick();

        // Backpressure: EX stalls for three cycles.
        applyStimulus(1'b1, 32'h200, ADDI_X5_X1_M1);
        tick();
        i_ex_ready = 1'b0;
        applyStimulus(1'b1, 32'h204, LUI_X6);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("stall_ready%0d", i), o_if_ready, 0);
            tick();
            checkOutput($sformatf("stall_pc%0d", i),    o_ex_pc,    32'h200);
            checkOutput($sformatf("stall_imm%0d", i),   o_ex_imm,   32'hFFFFFFFF);
            checkOutput($sformatf("stall_valid%0d", i), o_ex_valid, 1);
        end
        i_ex_ready = 1'b1;
        #1;
        checkOutput("release_ready", o_if_ready, 1);
        tick();
        checkOutput("release_pc",  o_ex_pc,  32'h204);
        checkOutput("release_imm", o_ex_imm, 32'h12345000);

        // Flush beats a stalled EX and a pending load-use hazard.
        applyStimulus(1'b1, 32'h300, LW_X6_X2);
        tick();
        i_ex_ready = 1'b0;
        i_flush    = 1'b1;
        applyStimulus(1'b1, 32'h304, ADD_X7_X6_X1);
        #1;
        checkOutput("flush_hazard", o_hazard, 1);
        tick();
        checkOutput("flush_valid", o_ex_valid, 0);
        i_flush    = 1'b0;
        i_ex_ready = 1'b1;
        tick();
        checkOutput("postflush_valid", o_ex_valid, 1);
        checkOutput("postflush_pc",    o_ex_pc,    32'h304);
        checkOutput("postflush_rd",    o_ex_rd,    7);

        // Mid-run reset with a write-back present: entry and registers cleared.
        i_rst = 1'b0;
        driveWb(1'b1, 5'd1, 32'h55);
        applyStimulus(1'b1, 32'h400, ADDI_X5_X1_M1);
        tick();
        checkOutput("mrst_valid", o_ex_valid, 0);
        checkOutput("mrst_pc",    o_ex_pc,    0);
        i_rst = 1'b1;
        driveWb(1'b0, '0, '0);
        tick();
        checkOutput("mrst_x1", o_ex_rs1_data, 0);
        checkOutput("mrst_v",  o_ex_valid,    1);
        applyStimulus(1'b1, 32'h404, ADDI_X8_X3);
        tick();
        checkOutput("mrst_x3", o_ex_rs1_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised RV32I instruction-decode stage with a registered ID/EX boundary.
- Takes fetched PC/instruction from IF over a valid/ready handshake and reads rs1/rs2 from an internal register file, with write-back bypass.
- Generates the sign-extended immediate for every base format and presents a registered ID/EX bundle to EX.
- Adds what earlier decode had none of: stall/backpressure, flush, load-use hazard bubbles and a per-entry valid bit.

Parameters:
- XLEN, 32, data/register width
- PC_W, 32, program counter width
- NREG, 32, architectural register count (x0 hard-wired zero)
- RA_W, 5, register address width, must satisfy 2**RA_W == NREG

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_if_valid  in  1  IF holds a valid instruction
- i_if_pc  in  PC_W  PC of fetched instruction
- i_if_inst  in  32  fetched instruction
- o_if_ready  out  1  ID accepts this cycle
- i_flush  in  1  kill the instruction entering ID/EX (branch/jump redirect)
- i_ex_ready  in  1  EX consumes the ID/EX entry this cycle
- i_wb_we  in  1  write-back enable
- i_wb_rd  in  RA_W  write-back destination
- i_wb_data  in  XLEN  write-back data
- o_ex_valid  out  1  ID/EX entry valid
- o_ex_pc  out  PC_W  registered PC
- o_ex_rs1_data  out  XLEN  rs1 operand
- o_ex_rs2_data  out  XLEN  rs2 operand
- o_ex_imm  out  XLEN  sign-extended immediate
- o_ex_rs1, o_ex_rs2, o_ex_rd  out  RA_W each  register addresses (for EX forwarding)
- o_ex_opcode  out  7  opcode[6:0]
- o_ex_funct3  out  3  funct3
- o_ex_funct7b5  out  1  inst[30]
- o_hazard  out  1  load-use bubble inserted this cycle

Behaviour:
- Reset (i_rst==0 at edge): all o_ex_* cleared to 0, o_ex_valid=0, every register-file entry cleared to 0. A mid-operation reset discards the in-flight entry; no write-back is performed in that cycle.
- Field extraction:
  - rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7]
  - opcode = inst[6:0], funct3 = inst[14:12]
- Register file:
  - Synchronous write when i_wb_we && i_wb_rd!=0; writes to x0 are ignored.
  - Combinational read; x0 reads 0.
  - Bypass: if i_wb_we && i_wb_rd==rsN && rsN!=0, the operand is i_wb_data (same-cycle write-through).
- Immediate, by opcode, sign-extended to XLEN:
  - I (0000011, 0010011, 1100111): inst[31:20]
  - S (0100011): {inst[31:25], inst[11:7]}
  - B (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U (0110111, 0010111): {inst[31:12], 12'b0}
  - J (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R type and unknown opcodes: 0
- Register usage for hazard checks: rs1 used by R/I/S/B; rs2 used by R/S/B; U/J use neither.
- Hazard: o_hazard = o_ex_valid && o_ex_opcode==0000011 && o_ex_rd!=0 && i_if_valid && (rs1 used and o_ex_rd==rs1, or rs2 used and o_ex_rd==rs2).
- Load enable: adv = !o_ex_valid || i_ex_ready.
- o_if_ready = adv && !o_hazard (combinational).
- Per clock edge, in priority order:
  1. Reset.
  2. i_flush: o_ex_valid<=0; other fields don't-care. Flush wins over stall and hazard.
  3. adv && o_hazard: bubble, o_ex_valid<=0; IF must hold its instruction.
  4. adv: capture the decoded bundle; o_ex_valid <= i_if_valid.
  5. Otherwise: hold every o_ex_* (stall).
- Latency: one cycle from accepted IF beat to a valid ID/EX entry.
- Throughput: one instruction per cycle absent stalls and hazards.
- An operand captured while EX is stalled does not see later write-backs. EX forwarding handles that case.

Decomposition:
- Shared package rv_pkg:
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_IMM, OP_REG)
  - field offsets RS1_LSB=15, RS2_LSB=20, RD_LSB=7
  - default XLEN/PC_W
- Sub-module id_regfile_bypass: NREG x XLEN array with synchronous reset, x0 rule and write-through bypass.
- Immediate generation stays a combinational function inside id_stage_pipe.

Test Plan:
- Reset: drive i_rst=0 for 2 cycles with i_if_valid=1 -> o_ex_valid=0, all o_ex_*=0, every register reads 0 afterwards.
- Decode/imm: addi x5,x1,-1 (0xFFF08293), PC 0x100, x1=7 -> next cycle o_ex_imm=0xFFFFFFFF, rs1_data=7, rd=5, pc=0x100. beq with imm -4 -> o_ex_imm=0xFFFFFFFC.
- Bypass/x0: WB x3=0xDEADBEEF in the same cycle ID reads x3 -> rs1_data=0xDEADBEEF. WB x0=5 -> x0 still reads 0.
- Load-use: lw x6,0(x2) followed by add x7,x6,x1 -> one bubble (o_hazard=1, o_if_ready=0, o_ex_valid=0) and the add enters one cycle later. lui x6 after the lw -> no bubble.
- Backpressure: i_ex_ready=0 for 3 cycles with o_ex_valid=1 -> o_if_ready=0 and o_ex_* stable; release -> next instruction captured.
- Flush priority: i_flush=1 together with i_ex_ready=0 and a pending hazard -> o_ex_valid=0 next cycle; following instruction decoded normally.
